// File: rtl/fifo_stream_reader_if.sv
// Downstream valid/ready word stream with a burst-end tag.
interface fifo_stream_reader_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO into a valid/ready stream. A 2-entry
// holding buffer absorbs the FIFO's one-cycle read latency, so pops can be
// issued speculatively while the consumer keeps full throughput.
module fifo_stream_reader #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 fifo_empty,
    output logic                 fifo_r_en,
    input  logic [DATA_W-1:0]    fifo_rdata,
    fifo_stream_reader_if.master out,
    output logic [CNT_W-1:0]     word_cnt,
    output logic [CNT_W-1:0]     burst_cnt
);
    localparam int              BW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0]   BEAT_MAX = BW'(BURST_LEN - 1);

    logic [1:0]             count_q, count_d;
    logic                   pending_q, pending_d;
    logic [1:0][DATA_W-1:0] buf_q, buf_d;
    logic                   head_q, head_d;
    logic                   tail_q, tail_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;

    logic                   pop;
    logic                   is_last;
    logic [2:0]             occ;

    assign word_cnt  = word_cnt_q;
    assign burst_cnt = burst_cnt_q;

    // Stream outputs and pop request. Buffer plus in-flight word may never
    // exceed two, counting the slot freed by a same-cycle pop.
    always_comb begin
        out.valid = (count_q != 2'd0);
        out.data  = out.valid ? buf_q[head_q] : '0;
        is_last   = (beat_q == BEAT_MAX);
        out.last  = out.valid & is_last;
        pop       = out.valid & out.ready;
        occ       = 3'(count_q) + 3'(pending_q);
        fifo_r_en = rst & enable & ~fifo_empty & (occ < (3'd2 + 3'(pop)));
    end

    // Next state: capture the word popped last cycle, retire the head on pop.
    always_comb begin
        count_d     = count_q + 2'(pending_q) - 2'(pop);
        pending_d   = fifo_r_en;
        buf_d       = buf_q;
        head_d      = head_q;
        tail_d      = tail_q;
        beat_d      = beat_q;
        word_cnt_d  = word_cnt_q;
        burst_cnt_d = burst_cnt_q;
        if (pending_q) begin
            buf_d[tail_q] = fifo_rdata;
            tail_d        = ~tail_q;
        end
        if (pop) begin
            head_d     = ~head_q;
            word_cnt_d = word_cnt_q + CNT_W'(1);
            beat_d     = is_last ? '0 : beat_q + BW'(1);
            if (is_last) begin
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset drops anything buffered or in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q     <= '0;
            pending_q   <= 1'b0;
            buf_q       <= '0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            beat_q      <= '0;
            word_cnt_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            count_q     <= count_d;
            pending_q   <= pending_d;
            buf_q       <= buf_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            beat_q      <= beat_d;
            word_cnt_q  <= word_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader with a behavioural registered-output FIFO.
module tb_fifo_stream_reader;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty;
    logic          fifo_r_en;
    logic [DW-1:0] fifo_rdata = '0;
    logic [CW-1:0] word_cnt, burst_cnt;

    fifo_stream_reader_if #(.DATA_W(DW)) out_if ();

    fifo_stream_reader #(.DATA_W(DW), .BURST_LEN(BL), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_rdata (fifo_rdata),
        .out        (out_if),
        .word_cnt   (word_cnt),
        .burst_cnt  (burst_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model plus monitor. Reset clears the FIFO unless the bench is
    // pushing on that edge, which lets words be preloaded during reset.
    logic [DW-1:0] fq[$];
    int            fcnt = 0;
    logic          push_en = 1'b0;
    logic [DW-1:0] push_data = '0;
    int            pops_issued = 0;
    logic          viol = 1'b0;
    logic [DW-1:0] got_data[$];
    logic          got_last[$];

    assign fifo_empty = (fcnt == 0);

    always @(posedge clk) begin
        if (!rst && !push_en) fq.delete();
        if (rst && fifo_r_en && fq.size() > 0) fifo_rdata <= fq.pop_front();
        if (push_en) fq.push_back(push_data);
        fcnt <= fq.size();
        if (fifo_r_en) pops_issued <= pops_issued + 1;
        if (fifo_r_en && (fifo_empty || !rst)) viol <= 1'b1;
        if (rst && out_if.valid && out_if.ready) begin
            got_data.push_back(out_if.data);
            got_last.push_back(out_if.last);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Hold reset, push n words base..base+n-1, then release at a negedge
    // so the caller starts in cycle 0 after reset.
    task automatic reset_preload(input int n, input logic [DW-1:0] base);
        @(negedge clk);
        rst = 1'b0;
        push_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            push_en = 1'b1;
            push_data = base + DW'(i);
            @(negedge clk);
        end
        push_en = 1'b0;
        rst = 1'b1;
    endtask

    typedef struct {
        logic          en;
        logic          rdy;
        logic          r_en;
        logic          vld;
        logic [DW-1:0] data;
        logic          last;
        logic [CW-1:0] wc;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g0, p0, sent, cyc;
        logic seen;

        //           en    rdy   r_en  vld   data   last  wc
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 4'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 4'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hA0, 1'b0, 4'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hA1, 1'b0, 4'd1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hA2, 1'b0, 4'd2};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 4'd3};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 4'd3};

        out_if.ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", out_if.valid, 0);
        check("rst_data", out_if.data, 0);
        check("rst_r_en", fifo_r_en, 0);
        check("rst_wc", word_cnt, 0);

        // Basic: cycle-by-cycle table
        enable = 1'b1;
        out_if.ready = 1'b1;
        reset_preload(3, 32'hA0);
        for (int i = 0; i < 7; i++) begin
            enable = tbl[i].en;
            out_if.ready = tbl[i].rdy;
            #1;
            check($sformatf("basic_r_en[%0d]", i), fifo_r_en, tbl[i].r_en);
            check($sformatf("basic_vld[%0d]", i), out_if.valid, tbl[i].vld);
            check($sformatf("basic_data[%0d]", i), out_if.data, tbl[i].data);
            check($sformatf("basic_last[%0d]", i), out_if.last, tbl[i].last);
            check($sformatf("basic_wc[%0d]", i), word_cnt, tbl[i].wc);
            @(negedge clk);
        end

        // Backpressure: only two pops with ready low, then gapless drain
        enable = 1'b1;
        out_if.ready = 1'b0;
        p0 = pops_issued;
        reset_preload(5, 32'd1);
        repeat (6) @(negedge clk);
        #1;
        check("bp_pops", pops_issued - p0, 2);
        check("bp_r_en", fifo_r_en, 0);
        check("bp_valid", out_if.valid, 1);
        check("bp_data_held", out_if.data, 1);
        check("bp_fifo_left", fcnt, 3);
        out_if.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_drain_vld[%0d]", i), out_if.valid, 1);
            check($sformatf("bp_drain_data[%0d]", i), out_if.data, i + 1);
            @(negedge clk);
        end
        #1;
        check("bp_end_valid", out_if.valid, 0);
        check("bp_fifo_empty", fcnt, 0);

        // Burst tagging: beats 4 and 8 carry last
        @(negedge clk);
        g0 = got_data.size();
        reset_preload(9, 32'h10);
        repeat (14) @(negedge clk);
        check("burst_wc", word_cnt, 9);
        check("burst_bc", burst_cnt, 2);
        check("burst_n", got_data.size() - g0, 9);
        for (int i = 0; i < 9 && g0 + i < got_data.size(); i++) begin
            check($sformatf("burst_data[%0d]", i), got_data[g0 + i], 32'h10 + i);
            check($sformatf("burst_last[%0d]", i), got_last[g0 + i], (i == 3 || i == 7));
        end

        // Enable gap after two pops
        g0 = got_data.size();
        enable = 1'b1;
        out_if.ready = 1'b1;
        reset_preload(6, 32'h20);
        #1;
        check("gap_r_en0", fifo_r_en, 1);
        @(negedge clk);
        #1;
        check("gap_r_en1", fifo_r_en, 1);
        @(negedge clk);
        enable = 1'b0;
        p0 = pops_issued;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("gap_no_pop[%0d]", i), fifo_r_en, 0);
            @(negedge clk);
        end
        check("gap_pending_out", got_data.size() - g0, 2);
        enable = 1'b1;
        repeat (12) @(negedge clk);
        check("gap_pops", pops_issued - p0, 4);
        check("gap_n", got_data.size() - g0, 6);
        for (int i = 0; i < 6 && g0 + i < got_data.size(); i++) begin
            check($sformatf("gap_data[%0d]", i), got_data[g0 + i], 32'h20 + i);
            check($sformatf("gap_last[%0d]", i), got_last[g0 + i], (i == 3));
        end
        check("gap_wc", word_cnt, 6);
        check("gap_bc", burst_cnt, 1);

        // Reset mid-operation with a full buffer
        enable = 1'b1;
        out_if.ready = 1'b0;
        reset_preload(4, 32'h40);
        repeat (2) @(negedge clk);
        out_if.ready = 1'b1;
        @(negedge clk);
        out_if.ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("mid_wc_before", word_cnt, 1);
        check("mid_valid_before", out_if.valid, 1);
        check("mid_data_before", out_if.data, 32'h41);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_r_en_in_rst", fifo_r_en, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_valid", out_if.valid, 0);
        check("mid_data", out_if.data, 0);
        check("mid_wc", word_cnt, 0);
        check("mid_fifo_cleared", fcnt, 0);
        @(negedge clk);
        push_en = 1'b1;
        push_data = 32'h55;
        out_if.ready = 1'b1;
        @(negedge clk);
        push_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (out_if.valid) begin
                seen = 1'b1;
                check("mid_refill_data", out_if.data, 32'h55);
            end else begin
                @(negedge clk);
            end
        end
        check("mid_refill_seen", seen, 1);
        @(negedge clk);

        // Counter wrap with random writes and random backpressure
        g0 = got_data.size();
        enable = 1'b1;
        out_if.ready = 1'b0;
        reset_preload(0, '0);
        sent = 0;
        cyc = 0;
        while ((sent < 17 || got_data.size() - g0 < 17) && cyc < 600) begin
            push_en = (sent < 17) && ($urandom_range(0, 1) == 1);
            push_data = 32'h300 + DW'(sent);
            if (push_en) sent++;
            out_if.ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            cyc++;
        end
        push_en = 1'b0;
        out_if.ready = 1'b1;
        repeat (4) @(negedge clk);
        check("wrap_timeout", (cyc < 600), 1);
        check("wrap_n", got_data.size() - g0, 17);
        check("wrap_wc", word_cnt, 1);
        check("wrap_bc", burst_cnt, 4);
        for (int i = 0; i < 17 && g0 + i < got_data.size(); i++) begin
            check($sformatf("wrap_data[%0d]", i), got_data[g0 + i], 32'h300 + i);
        end
        check("r_en_while_empty_or_rst", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain engine for the team's 32-bit synchronous FIFO. It issues pops against the FIFO's read port (r_en / empty / registered data_out) and absorbs the FIFO's one-cycle read latency in a 2-entry holding buffer. It presents the words downstream on a valid/ready stream, tagged with burst boundaries, with full throughput and no loss or duplication under backpressure. It sits between the FIFO's read port and any stream consumer.

## Interface
- DATA_W, 32, word width; matches the FIFO data width
- BURST_LEN, 16, beats per burst; out_last marks the final beat; legal range >= 1
- CNT_W, 16, width of the word_cnt and burst_cnt status counters
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-low; shared with the FIFO
- enable  in  1  permits new pops; does not affect words already in flight or buffered
- fifo_empty  in  1  FIFO empty flag
- fifo_r_en  out  1  FIFO read enable (pop request)
- fifo_rdata  in  DATA_W  FIFO registered read data; valid the cycle after an accepted pop
- out_valid  out  1  head word available
- out_ready  in  1  consumer accepts head word
- out_data  out  DATA_W  head word
- out_last  out  1  head word is beat BURST_LEN-1 of its burst
- word_cnt  out  CNT_W  words delivered since reset, modulo 2^CNT_W
- burst_cnt  out  CNT_W  bursts completed since reset, modulo 2^CNT_W

## Operation
- State:
  - count: buffer occupancy, 0..2
  - pending: 1 when a pop was accepted in the previous cycle
  - 2-entry buffer with head/tail indices
  - beat_idx: 0..BURST_LEN-1
  - word_cnt, burst_cnt
- pop = out_valid & out_ready.
- space = 2 - count - pending + pop.
- fifo_r_en = rst & enable & !fifo_empty & (space >= 1). The block never asserts fifo_r_en while fifo_empty = 1.
- Capture: when pending = 1, fifo_rdata is written into the tail entry on that edge.
- Next state:
  - count_next = count + pending - pop
  - pending_next = fifo_r_en
  - The invariant count + pending <= 2 holds every cycle.
- Outputs:
  - out_valid = (count != 0)
  - out_data = head entry; 0 when count = 0
  - out_last = out_valid & (beat_idx == BURST_LEN-1)
- Per pop:
  - head advances and word_cnt increments.
  - beat_idx increments, wrapping to 0 after BURST_LEN-1.
  - If out_last, burst_cnt increments.
- BURST_LEN = 1: every valid beat has out_last = 1 and burst_cnt tracks word_cnt.
- Counters wrap silently; there is no saturation.
- Simultaneous capture and pop at count = 2 is not possible by construction. At count = 1, capture and pop in the same cycle leaves count = 1 with the new word at the head.
- enable low: no new pops. The pending word is still captured and buffered words still drain. beat_idx is preserved, so a burst may span an enable gap.
- fifo_empty rising while pending = 1: the pending capture completes normally.

## Timing
- Reset (rst = 0 at an edge) clears:
  - count, pending, head/tail, beat_idx, word_cnt, burst_cnt = 0
  - out_valid = 0, out_data = 0, out_last = 0
  - fifo_r_en is forced to 0 while rst = 0.
- Reset mid-operation discards buffered and in-flight words without delivering them. The FIFO is reset by the same rst.
- Latency: pop accepted at edge N; word captured at edge N+1; out_valid = 1 in the cycle after edge N+1.
- First word after reset release, with a non-empty FIFO: fifo_r_en high in the first cycle with rst = 1; out_valid two cycles later.
- Throughput: one word per cycle sustained while out_ready = 1 and the FIFO is non-empty.
- Backpressure: with out_ready held low, at most 2 pops are issued, then fifo_r_en stays 0.
- out_data and out_last are stable while out_valid & !out_ready.
- out_valid never deasserts without a pop, except on reset.

## Test plan
- Basic: FIFO preloaded with 0xA0, 0xA1, 0xA2; enable = 1; out_ready = 1; release reset -> fifo_r_en high cycle 0; out_valid cycles 2-4 with data 0xA0, 0xA1, 0xA2 back-to-back; word_cnt = 3; then out_valid = 0 and fifo_r_en = 0.
- Backpressure: 5 words 1..5 loaded, out_ready = 0 -> exactly 2 pops, out_valid = 1, out_data = 1 held. Raise out_ready -> 1..5 delivered in order with no gaps after the first; FIFO ends empty.
- Burst: BURST_LEN = 4, 9 words -> out_last on beats 4 and 8 only; burst_cnt = 2; word_cnt = 9.
- Enable gap: stream 6 words, drop enable after 2 pops, hold 5 cycles, restore -> words still delivered in order; no pop while enable = 0; the pending word is still delivered.
- Reset mid-operation: count = 2 with out_ready = 0, assert rst low for one edge -> out_valid = 0, out_data = 0, word_cnt = 0 next cycle. After refill with 0x55, the first word out is 0x55.
- Wrap and random: CNT_W = 4, 17 words with random out_ready and random FIFO writes -> word_cnt = 1, order preserved, no duplicates, fifo_r_en never high while fifo_empty = 1.
